// File: rtl/alu_pkg.sv
// Shared definitions for the two-requester ALU arbiter.
//   - ALU op-code constants (4-bit ctl field)
//   - FSM state encoding for the arbiter's request/execute/respond sequence
package alu_pkg;

  localparam int CTL_W = 4;

  localparam logic [CTL_W-1:0] ALU_AND  = 4'd0;
  localparam logic [CTL_W-1:0] ALU_OR   = 4'd1;
  localparam logic [CTL_W-1:0] ALU_ADD  = 4'd2;
  localparam logic [CTL_W-1:0] ALU_SUB  = 4'd6;
  localparam logic [CTL_W-1:0] ALU_SLTU = 4'd7;
  localparam logic [CTL_W-1:0] ALU_XOR  = 4'd12;

  // IDLE accepts one request, EXEC registers the ALU result,
  // RESP holds it until the consumer takes it.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU.
// Ports:
//   ctl    : op code (see alu_pkg)
//   a, b   : WIDTH-bit operands
//   result : WIDTH-bit result; unsupported op codes yield 0
// ADD/SUB wrap modulo 2^WIDTH; SLTU is an unsigned compare returning 0/1.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [CTL_W-1:0] ctl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = '0;
    case (ctl)
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_SLTU: result[0] = (a < b);
      ALU_XOR:  result = a ^ b;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter in front of a single shared ALU.
// Ports:
//   clk, reset                 : clock, async active-high reset
//   reqN_valid / reqN_ready    : per-requester handshake (N = 0, 1)
//   reqN_ctl, reqN_a, reqN_b   : per-requester op code and operands
//   rsp_valid / rsp_ready      : result handshake
//   rsp_id                     : requester that issued the result
//   rsp_result, rsp_zero       : registered result and its zero flag
// One operation is in flight at a time: IDLE (grant) -> EXEC (compute)
// -> RESP (hold until taken), so throughput is at most one op per 3 cycles.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int RR_INIT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_ctl,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_ctl,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero
);

  localparam logic LAST_INIT = (RR_INIT != 0);

  state_t state, state_nxt;
  logic   last;                // index granted most recently

  logic   gnt_vld;
  logic   gnt_id;
  logic [1:0] valid_vec;
  logic [1:0] ready_vec;

  // Operation captured at handshake; inputs may change freely afterwards.
  logic [3:0]       op_ctl;
  logic [WIDTH-1:0] op_a, op_b;
  logic             op_id;
  logic [WIDTH-1:0] alu_res;

  assign valid_vec = {req1_valid, req0_valid};

  always_comb begin
    state_nxt = state;
    gnt_vld   = 1'b0;
    gnt_id    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (valid_vec == 2'b11) begin
          gnt_vld = 1'b1;
          gnt_id  = ~last;
        end else if (valid_vec[0]) begin
          gnt_vld = 1'b1;
          gnt_id  = 1'b0;
        end else if (valid_vec[1]) begin
          gnt_vld = 1'b1;
          gnt_id  = 1'b1;
        end
        // Ready is only ever raised for a valid requester, so a grant
        // is always a completed handshake.
        if (gnt_vld) state_nxt = ST_EXEC;
      end
      ST_EXEC: state_nxt = ST_RESP;
      ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Reset gates ready directly: state is already IDLE while reset is
  // held, and a requester must not see an accept then.
  assign ready_vec  = (gnt_vld && !reset) ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;
  assign req0_ready = ready_vec[0];
  assign req1_ready = ready_vec[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      last       <= LAST_INIT;
      op_ctl     <= '0;
      op_a       <= '0;
      op_b       <= '0;
      op_id      <= 1'b0;
      rsp_result <= '0;
      rsp_id     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && gnt_vld) begin
        op_ctl <= gnt_id ? req1_ctl : req0_ctl;
        op_a   <= gnt_id ? req1_a   : req0_a;
        op_b   <= gnt_id ? req1_b   : req0_b;
        op_id  <= gnt_id;
        last   <= gnt_id;
      end
      if (state == ST_EXEC) begin
        rsp_result <= alu_res;
        rsp_id     <= op_id;
      end
    end
  end

  alu_core #(.WIDTH(WIDTH)) u_alu (
    .ctl    (op_ctl),
    .a      (op_a),
    .b      (op_b),
    .result (alu_res)
  );

  assign rsp_valid = (state == ST_RESP);
  // Taken from the registered result, so it holds with it and reads 1 in reset.
  assign rsp_zero  = (rsp_result == '0);

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a transaction-level model predicts
// grants, ready/valid timing and results; a monitor compares responses.
module tb_alu_arbiter;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         req0_valid = 0, req1_valid = 0;
  logic         req0_ready, req1_ready;
  logic [3:0]   req0_ctl = 0, req1_ctl = 0;
  logic [W-1:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic         rsp_valid, rsp_ready = 0, rsp_id, rsp_zero;
  logic [W-1:0] rsp_result;

  alu_arbiter #(.WIDTH(W), .RR_INIT(1)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctl(req0_ctl),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctl(req1_ctl),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         id;
    logic [W-1:0] result;
    logic         zero;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Model: busy tracks where the accepted op is (0 free, 1 computing,
  // 2 waiting to be taken); last_g is the requester granted last.
  int   busy   = 0;
  logic last_g = 1'b1;

  function automatic logic [W-1:0] ref_alu(input logic [3:0] c,
                                           input logic [W-1:0] a, b);
    case (c)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a + b;
      4'd6:    return a - b;
      4'd7:    return (a < b) ? 1 : 0;
      4'd12:   return a ^ b;
      default: return 0;
    endcase
  endfunction

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle of stimulus plus model prediction for that cycle.
  task automatic step(input logic v0, input logic [3:0] c0,
                      input logic [W-1:0] a0, input logic [W-1:0] b0,
                      input logic v1, input logic [3:0] c1,
                      input logic [W-1:0] a1, input logic [W-1:0] b1,
                      input logic rr);
    logic gv, g;
    logic [W-1:0] r;
    @(negedge clk);
    req0_valid = v0; req0_ctl = c0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_ctl = c1; req1_a = a1; req1_b = b1;
    rsp_ready  = rr;
    #1;
    gv = 1'b0; g = 1'b0;
    if (busy == 0) begin
      if (v0 && v1) begin gv = 1'b1; g = ~last_g; end
      else if (v0)  begin gv = 1'b1; g = 1'b0; end
      else if (v1)  begin gv = 1'b1; g = 1'b1; end
    end
    check("req0_ready", {31'b0, req0_ready}, {31'b0, gv && !g});
    check("req1_ready", {31'b0, req1_ready}, {31'b0, gv && g});
    check("rsp_valid",  {31'b0, rsp_valid},  (busy == 2) ? 1 : 0);
    if (busy == 0 && gv) begin
      r = g ? ref_alu(c1, a1, b1) : ref_alu(c0, a0, b0);
      sb.push_back('{id: g, result: r, zero: (r == 0)});
      last_g = g;
      busy = 1;
    end else if (busy == 1) begin
      busy = 2;
    end else if (busy == 2 && rr) begin
      busy = 0;
    end
  endtask

  task automatic idle(input logic rr);
    step(0, 0, 0, 0, 0, 0, 0, 0, rr);
  endtask

  task automatic op0(input logic [3:0] c, input logic [W-1:0] a, b);
    step(1, c, a, b, 0, 0, 0, 0, 1);
    idle(1);
    idle(1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    #1;
    check("rst_req0_ready", {31'b0, req0_ready}, 0);
    check("rst_req1_ready", {31'b0, req1_ready}, 0);
    check("rst_rsp_valid",  {31'b0, rsp_valid},  0);
    check("rst_rsp_result", rsp_result,          0);
    check("rst_rsp_zero",   {31'b0, rsp_zero},   1);
    check("rst_rsp_id",     {31'b0, rsp_id},     0);
    sb.delete();
    busy   = 0;
    last_g = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  // Monitor: every presented response must match the oldest expectation;
  // while it is not taken, the same entry is rechecked (stability).
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!reset && rsp_valid) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_rsp: got result=%0h id=%0d expected=no response",
                   rsp_result, rsp_id);
        end else begin
          e = sb[0];
          check("rsp_id",     {31'b0, rsp_id},   {31'b0, e.id});
          check("rsp_result", rsp_result,        e.result);
          check("rsp_zero",   {31'b0, rsp_zero}, {31'b0, e.zero});
          if (rsp_ready) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] codes [6];
    logic [3:0] c0, c1;
    logic [W-1:0] a0, b0, a1, b1;
    codes = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12};

    do_reset();
    // Single request from requester 0
    op0(4'd2, 5, 7);

    // Both valid continuously: grants alternate starting with 0
    do_reset();
    for (int i = 0; i < 12; i++)
      step(1, 4'd2, W'(i), 1, 1, 4'd6, 3, 3, 1);
    idle(1); idle(1); idle(1);

    // Op-code corners
    op0(4'd6, 0, 1);
    op0(4'd7, 32'hFFFF_FFFF, 1);
    op0(4'd12, 32'h0000_F0F0, 32'h0000_FF00);
    op0(4'd3, 32'h1234, 32'h5678);
    op0(4'd7, 1, 32'hFFFF_FFFF);
    op0(4'd2, 32'hFFFF_FFFF, 2);

    // Back-pressure: result held 5 cycles while requester 1 waits
    step(1, 4'd1, 32'hA0, 32'h0B, 1'b0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1, 4'd0, 32'hFF, 32'h0F, 0);
    step(0, 0, 0, 0, 1, 4'd0, 32'hFF, 32'h0F, 1);
    step(0, 0, 0, 0, 1, 4'd0, 32'hFF, 32'h0F, 1);
    idle(1); idle(1); idle(1);

    // Reset while the op is computing: nothing must come out
    step(1, 4'd2, 100, 200, 0, 0, 0, 0, 1);
    do_reset();
    idle(1); idle(1);
    op0(4'd2, 40, 2);

    // Operand changes after handshake must not leak into the result
    step(1, 4'd2, 10, 20, 0, 0, 0, 0, 1);
    step(1, 4'd2, 999, 20, 0, 0, 0, 0, 1);
    step(0, 4'd2, 777, 20, 0, 0, 0, 0, 1);
    idle(1); idle(1); idle(1);

    // Randomized traffic with random back-pressure
    for (int i = 0; i < 500; i++) begin
      c0 = ($urandom_range(0, 4) != 0) ? codes[$urandom_range(0, 5)] : 4'($urandom_range(0, 15));
      c1 = ($urandom_range(0, 4) != 0) ? codes[$urandom_range(0, 5)] : 4'($urandom_range(0, 15));
      a0 = $urandom; a1 = $urandom;
      b0 = ($urandom_range(0, 3) == 0) ? a0 : $urandom;
      b1 = ($urandom_range(0, 3) == 0) ? a1 : $urandom;
      step($urandom_range(0, 9) < 6, c0, a0, b0,
           $urandom_range(0, 9) < 6, c1, a1, b1,
           $urandom_range(0, 9) < 7);
    end

    for (int i = 0; i < 5; i++) idle(1);
    check("sb_drained", W'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
